// File: rtl/alu_op_sequencer.sv
// Multi-cycle controller for the BreadBoard ALU: one shared adder serves
// add/sub, shift-add multiply and restoring divide through a small FSM.
module alu_op_sequencer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] inputA,
  input  logic [WIDTH-1:0] inputB,
  input  logic [3:0]       command,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] result,
  output logic             error,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ADDSUB = 2'd1;
  localparam logic [1:0] S_ITER   = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic [3:0] C_ADD = 4'd1;
  localparam logic [3:0] C_SUB = 4'd2;
  localparam logic [3:0] C_MUL = 4'd3;
  localparam logic [3:0] C_DIV = 4'd4;
  localparam logic [3:0] C_MOD = 4'd5;

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [3:0]       cmd_r;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  logic is_sub;
  logic is_mul;
  logic is_dm;
  logic is_mod;

  assign is_sub = (cmd_r == C_SUB);
  assign is_mul = (cmd_r == C_MUL);
  assign is_mod = (cmd_r == C_MOD);
  assign is_dm  = (cmd_r == C_DIV) | is_mod;

  logic in_as;
  logic in_it;

  assign in_as = (command == C_ADD) | (command == C_SUB);
  assign in_it = (command == C_MUL) | (command == C_DIV)
               | (command == C_MOD);

  // Shared adder, one bit wider than needed so the divide borrow is visible.
  logic [WIDTH:0]   x;
  logic [WIDTH:0]   y;
  logic             inv;
  logic [WIDTH+1:0] sum;

  always_comb begin
    x   = {1'b0, a_r};
    y   = {1'b0, b_r};
    inv = 1'b0;
    unique case (1'b1)
      is_sub: inv = 1'b1;
      is_mul: begin
        x = {1'b0, hi};
        y = {1'b0, a_r};
      end
      is_dm: begin
        x   = {hi, lo[WIDTH-1]};
        inv = 1'b1;
      end
      default: ;
    endcase
  end

  assign sum = {1'b0, x}
             + {1'b0, y ^ {(WIDTH+1){inv}}}
             + {{(WIDTH+1){1'b0}}, inv};

  logic [WIDTH-1:0] bb;
  logic             ovf;

  assign bb  = b_r ^ {WIDTH{is_sub}};
  assign ovf = (a_r[WIDTH-1] ~^ bb[WIDTH-1])
             & (sum[WIDTH-1] ^ a_r[WIDTH-1]);

  logic [WIDTH-1:0] mul_hi;
  logic [WIDTH-1:0] mul_lo;
  logic             ok;
  logic [WIDTH-1:0] rem_n;
  logic [WIDTH-1:0] quo_n;
  logic [WIDTH-1:0] hi_n;
  logic [WIDTH-1:0] lo_n;

  assign mul_hi = lo[0] ? sum[WIDTH:1] : {1'b0, hi[WIDTH-1:1]};
  assign mul_lo = {lo[0] ? sum[0] : hi[0], lo[WIDTH-1:1]};

  // Restoring step: keep the difference only when no borrow occurred.
  assign ok    = sum[WIDTH+1];
  assign rem_n = ok ? sum[WIDTH-1:0] : {hi[WIDTH-2:0], lo[WIDTH-1]};
  assign quo_n = {lo[WIDTH-2:0], ok};

  assign hi_n = is_mul ? mul_hi : rem_n;
  assign lo_n = is_mul ? mul_lo : quo_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      cnt    <= '0;
      a_r    <= '0;
      b_r    <= '0;
      cmd_r  <= '0;
      hi     <= '0;
      lo     <= '0;
      result <= '0;
      error  <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (req_valid) begin
            a_r   <= inputA;
            b_r   <= inputB;
            cmd_r <= command;
            cnt   <= '0;
            hi    <= '0;
            lo    <= (command == C_MUL) ? inputB : inputA;
            unique case (1'b1)
              in_as: state <= S_ADDSUB;
              in_it: state <= S_ITER;
              default: begin
                state  <= S_DONE;
                result <= '0;
                error  <= 1'b1;
              end
            endcase
          end
        end
        S_ADDSUB: begin
          result <= sum[WIDTH-1:0];
          error  <= ovf;
          state  <= S_DONE;
        end
        S_ITER: begin
          hi  <= hi_n;
          lo  <= lo_n;
          cnt <= cnt + CW'(1);
          if (cnt == LAST) begin
            state  <= S_DONE;
            result <= is_mul ? mul_lo : (is_mod ? rem_n : quo_n);
            error  <= is_mul ? (|mul_hi) : (b_r == '0);
          end
        end
        S_DONE: begin
          if (rsp_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign req_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign rsp_valid = (state == S_DONE);

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer: a driver queues expected
// responses from an arithmetic model, a monitor pops and compares.
module tb_alu_op_sequencer;
  localparam int W    = 4;
  localparam int MASK = (1 << W) - 1;
  localparam int SMAX = (1 << (W - 1)) - 1;
  localparam int SMIN = -(1 << (W - 1));

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [W-1:0] inputA = '0;
  logic [W-1:0] inputB = '0;
  logic [3:0]   command = '0;
  logic         rsp_valid;
  logic         rsp_ready = 1'b0;
  logic [W-1:0] result;
  logic         error;
  logic         busy;

  alu_op_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .inputA(inputA), .inputB(inputB), .command(command),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .result(result), .error(error), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int res; int err; int lat; int e0;
    int cmd; int a; int b;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_pass = 0;
  int   hold_n = 0;
  bit   seen = 0;
  bit   post = 0;
  int   first_r;
  int   first_e;

  task automatic chk(string nm, int act, int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)",
                  nm, act, exp, $time);
  endtask

  function automatic int sx(int v);
    return (v > SMAX) ? v - (1 << W) : v;
  endfunction

  function automatic exp_t model(int cmd, int a, int b);
    exp_t e;
    int s;
    e.cmd = cmd; e.a = a; e.b = b; e.e0 = 0;
    e.res = 0; e.err = 1; e.lat = 1;
    case (cmd)
      1: begin
        s = sx(a) + sx(b);
        e.res = s & MASK; e.err = (s > SMAX || s < SMIN); e.lat = 2;
      end
      2: begin
        s = sx(a) - sx(b);
        e.res = s & MASK; e.err = (s > SMAX || s < SMIN); e.lat = 2;
      end
      3: begin
        s = a * b;
        e.res = s & MASK; e.err = (s > MASK); e.lat = W + 1;
      end
      4: begin
        e.res = (b == 0) ? MASK : a / b;
        e.err = (b == 0); e.lat = W + 1;
      end
      5: begin
        e.res = (b == 0) ? a : a % b;
        e.err = (b == 0); e.lat = W + 1;
      end
      default: ;
    endcase
    return e;
  endfunction

  task automatic issue(int cmd, int a, int b);
    exp_t e;
    int t;
    e = model(cmd, a, b);
    @(negedge clk);
    command = cmd[3:0]; inputA = a[W-1:0]; inputB = b[W-1:0];
    req_valid = 1'b1;
    t = 0;
    while (!req_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!req_ready) begin
      chk("accept_timeout", 0, 1);
      req_valid = 1'b0;
      return;
    end
    e.e0 = cyc + 1;
    q.push_back(e);
    @(posedge clk);
    #1;
    // Scribble on the request port while busy; it must be ignored.
    command = 4'($urandom); inputA = W'($urandom); inputB = W'($urandom);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((q.size() != 0 || post) && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (q.size() != 0 || post) chk("drain_timeout", 0, 1);
  endtask

  initial begin
    exp_t f;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (post) begin
          chk("rsp_valid_fall", rsp_valid, 0);
          chk("req_ready_after", req_ready, 1);
          post = 0;
        end else if (rsp_valid) begin
          if (!seen) begin
            seen = 1; first_r = result; first_e = error;
            if (q.size() == 0) chk("spurious_rsp", 1, 0);
            else chk($sformatf("latency_cmd%0d", q[0].cmd),
                     cyc - q[0].e0 + 1, q[0].lat);
          end else begin
            chk("hold_result", result, first_r);
            chk("hold_error", error, first_e);
            chk("hold_req_ready", req_ready, 0);
          end
          if (hold_n > 0) begin
            hold_n--;
            rsp_ready = 1'b0;
          end else begin
            rsp_ready = ($urandom % 3 != 0);
          end
          if (rsp_ready) begin
            if (q.size() > 0) begin
              f = q.pop_front();
              chk($sformatf("result c%0d a%0d b%0d", f.cmd, f.a, f.b),
                  result, f.res);
              chk($sformatf("error c%0d a%0d b%0d", f.cmd, f.a, f.b),
                  error, f.err);
            end
            seen = 0;
            post = 1;
          end
        end else begin
          rsp_ready = 1'($urandom);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    #12;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_error", error, 0);
    @(negedge clk);
    rst_n = 1'b1;

    issue(1, 6, 1);  issue(1, 7, 1);
    issue(2, 5, 7);  issue(2, 8, 1);
    issue(3, 3, 5);  issue(3, 4, 5);
    issue(4, 13, 4); issue(5, 13, 4);
    issue(4, 9, 0);  issue(5, 9, 0);
    drain();

    hold_n = 3;
    issue(7, 2, 3);
    drain();

    issue(3, 3, 5);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_rsp_valid", rsp_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_req_ready", req_ready, 1);
    chk("mid_rst_result", result, 0);
    chk("mid_rst_error", error, 0);
    q.delete();
    seen = 0; post = 0; hold_n = 0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("no_rsp_after_rst", rsp_valid, 0);
    end
    issue(1, 2, 2);
    drain();

    repeat (150) begin
      if ($urandom % 8 == 0) begin
        c = $urandom_range(6, 16);
        if (c == 16) c = 0;
      end else begin
        c = $urandom_range(1, 5);
      end
      issue(c, $urandom_range(0, MASK), $urandom_range(0, MASK));
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
